multicyc_exec: RTL
==================

Name: multicyc_exec

Overview:
- Responder side of the multicycle-execute request/response pair.
- Consumes `multicyc_req_t` from the EX stage and returns `multicyc_resp_t` carrying the 64-bit HI/LO result {hi, lo}.
- Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL on a pipelined multiplier, and DIV/DIVU on an iterative radix-2 divider.
- EX stalls while `resp.ready` is low.

Parameters:
- MUL_CYCLES, 3, cycles from accept to result for all multiply-class ops (min 1).
- DIV_ITER, 32, divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; aborts any in-flight operation.
- stall  in  1  downstream stall; holds a completed result in DONE.
- req  in  $bits(multicyc_req_t)  {op, is_multicyc, hilo, reg0, reg1}; held stable by EX until `resp.ready`.
- resp  out  $bits(multicyc_resp_t)  {ready, valid, hilo}; `ready` always equals `valid`.

Behaviour:
- Encoding: hilo[63:32]=HI, hilo[31:0]=LO.
- FSM states: IDLE, MUL_WAIT, DIV_CALC, DIV_FIX, DONE.
- Reset: state=IDLE, result register=0, counters=0. `resp.valid`/`ready`/`hilo` are 0 in the cycle after reset is applied.
- Pass-through: in IDLE with `req.is_multicyc`=0, `resp.valid`=`ready`=1 combinationally and `resp.hilo`=`req.hilo`. No state change.
- Accept: in IDLE with `is_multicyc`=1 (cycle t), operands, op and `req.hilo` are latched. `resp.valid`=0 from cycle t until completion.
- Multiply class (op in MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL):
  - Product is 64-bit, signed for MULT/MADD/MSUB/MUL and unsigned otherwise.
  - MADD/MADDU: result = latched hilo + product. MSUB/MSUBU: result = latched hilo − product. Both are 64-bit wrap-around.
  - MULT/MULTU/MUL: result = product. For MUL the consumer uses LO only.
  - State goes to MUL_WAIT; the counter counts MUL_CYCLES−1 cycles; then DONE. Result is valid in cycle t+MUL_CYCLES.
- Divide (DIV, DIVU):
  - Operands are converted to magnitudes (signed for DIV).
  - DIV_CALC runs DIV_ITER restoring iterations.
  - DIV_FIX: quotient is negated if signs differ; remainder takes the dividend's sign.
  - Then DONE. Result is valid in cycle t+DIV_ITER+2 (t+34 by default).
  - Output: LO=quotient, HI=remainder.
  - Divide by zero: magnitude quotient = 0xFFFFFFFF and remainder = dividend, before DIV_FIX. No exception.
  - INT_MIN/−1 for DIV: LO=0x80000000, HI=0.
- DONE: `resp.valid`=`ready`=1 and `resp.hilo`=result register. Stay in DONE while `stall`=1; go to IDLE when `stall`=0.
- The IDLE after DONE must not re-accept the same held request. EX advances `req` in the same cycle DONE exits.
- Flush: highest priority in every state. The next state is IDLE, the in-flight result is discarded, and `resp.valid`=0 that cycle. The IDLE pass-through rule still applies combinationally.
- Simultaneous flush and accept in IDLE: no accept.
- Unknown op with `is_multicyc`=1: complete in 1 cycle (DONE) with hilo = latched `req.hilo`.
- `rst` mid-operation: same as flush, and the result register is also cleared.

Decomposition:
- `multicyc_req_t`, `multicyc_resp_t`, `oper_t` and the FSM state enum belong in the shared CPU defs header. Add the state enum as `multicyc_state_t`.
- The op-class helper functions (`is_mul_op`, `is_div_op`, `is_signed_op`) also go in the shared header.
- One sub-module, `multicyc_div`:
  - Inputs: clk, rst, abort, start, signed_op, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Contains DIV_CALC/DIV_FIX internally.
- The multiplier stays inline as MUL_CYCLES−1 register stages for DSP inference.

Test Plan:
- MULT reg0=0xFFFFFFFE (−2), reg1=3 -> `resp.valid` at t+3, hilo=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> hilo=0x00000002_FFFFFFFA.
- MADD hilo=0x00000000_00000010, reg0=4, reg1=5 -> 0x00000000_00000024. MSUBU hilo=0, reg0=1, reg1=1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV reg0=−7 (0xFFFFFFF9), reg1=2 -> valid at t+34, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x80000000/0 -> LO=0xFFFFFFFF, HI=0x80000000.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV, assert flush at t+10 -> `resp.valid`=0 and state IDLE at t+11. A new MULT 6×7 issued at t+12 -> valid at t+15, hilo=42.
- DONE with `stall`=1 for 5 cycles -> valid held with constant hilo; `stall`=0 -> IDLE next cycle, no re-execution. Request with `is_multicyc`=0, hilo=0x1234 -> same-cycle valid, hilo=0x1234.

Source files
------------

// File: rtl/multicyc_exec_pkg.sv
// Shared CPU definitions for the multicycle-execute request/response pair:
// operation codes, request/response records, FSM states and op-class helpers.
package multicyc_exec_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_MUL   = 4'd7,
        OP_DIV   = 4'd8,
        OP_DIVU  = 4'd9,
        OP_MTHI  = 4'd10,
        OP_MTLO  = 4'd11
    } oper_t;

    typedef struct packed {
        oper_t       op;
        logic        is_multicyc;
        logic [63:0] hilo;
        logic [31:0] reg0;
        logic [31:0] reg1;
    } multicyc_req_t;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [63:0] hilo;
    } multicyc_resp_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_CALC = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } multicyc_state_t;

    function automatic logic is_mul_op(input oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
    endfunction

    function automatic logic is_div_op(input oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input oper_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/multicyc_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// followed by a single sign-fix cycle in which done is asserted.
module multicyc_div
    import multicyc_exec_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int IT_W = $clog2(DIV_ITER + 1);
    localparam logic [IT_W-1:0] ITER_LAST = IT_W'(DIV_ITER - 1);

    multicyc_state_t phase_q, phase_d;
    logic [IT_W-1:0] iter_q, iter_d;
    logic [31:0]     quo_q, quo_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     dsr_q, dsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            dvd_neg, dsr_neg;
    logic [32:0]     rem_shift;

    assign dvd_neg   = signed_op & dividend[31];
    assign dsr_neg   = signed_op & divisor[31];
    assign rem_shift = {rem_q, quo_q[31]};

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        phase_d   = phase_q;
        iter_d    = iter_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (phase_q)
            S_IDLE: begin
                if (start) begin
                    quo_d     = dvd_neg ? -dividend : dividend;
                    dsr_d     = dsr_neg ? -divisor : divisor;
                    rem_d     = '0;
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    iter_d    = '0;
                    phase_d   = S_DIV_CALC;
                end
            end
            S_DIV_CALC: begin
                // A zero divisor always "fits", yielding all-ones and rem = dividend.
                if (rem_shift >= {1'b0, dsr_q}) begin
                    rem_d = rem_shift[31:0] - dsr_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (iter_q == ITER_LAST) begin
                    phase_d = S_DIV_FIX;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DIV_FIX: phase_d = S_IDLE;
            default:   phase_d = S_IDLE;
        endcase
        if (abort) begin
            phase_d = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= S_IDLE;
            iter_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            iter_q    <= iter_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign done      = (phase_q == S_DIV_FIX);
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/multicyc_exec.sv
// Multicycle-execute responder: pipelined multiply/accumulate, iterative divide,
// and combinational pass-through of HI/LO when no multicycle op is requested.
module multicyc_exec
    import multicyc_exec_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_ITER   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           stall,
    input  multicyc_req_t  req,
    output multicyc_resp_t resp
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);

    multicyc_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      result_q, result_d;
    logic             accept;

    logic [63:0]      mul_a, mul_b, mul_prod, mul_res0, mul_res;
    logic             div_done;
    logic [31:0]      div_quo, div_rem;

    // Sign- or zero-extend to 64 bits; the low 64 product bits are then correct for both.
    always_comb begin
        mul_a    = {{32{is_signed_op(req.op) & req.reg0[31]}}, req.reg0};
        mul_b    = {{32{is_signed_op(req.op) & req.reg1[31]}}, req.reg1};
        mul_prod = mul_a * mul_b;
        unique case (req.op)
            OP_MADD, OP_MADDU: mul_res0 = req.hilo + mul_prod;
            OP_MSUB, OP_MSUBU: mul_res0 = req.hilo - mul_prod;
            default:           mul_res0 = mul_prod;
        endcase
    end

    generate
        if (MUL_CYCLES > 1) begin : g_mul_pipe
            logic [63:0] pipe_q [MUL_CYCLES-1];
            // NOTE: datapath pipeline registers carry no reset; only the FSM decides
            // when their contents are meaningful, and this keeps them DSP-packable.
            always_ff @(posedge clk) begin
                pipe_q[0] <= mul_res0;
                for (int i = 1; i < MUL_CYCLES - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_res = pipe_q[MUL_CYCLES-2];
        end else begin : g_mul_comb
            assign mul_res = mul_res0;
        end
    endgenerate

    multicyc_div #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (accept & is_div_op(req.op)),
        .signed_op (is_signed_op(req.op)),
        .dividend  (req.reg0),
        .divisor   (req.reg1),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        accept   = 1'b0;
        resp     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!req.is_multicyc) begin
                    resp.valid = 1'b1;
                    resp.ready = 1'b1;
                    resp.hilo  = req.hilo;
                end else if (!flush) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (is_mul_op(req.op)) begin
                        if (MUL_CYCLES == 1) begin
                            result_d = mul_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_MUL_WAIT;
                        end
                    end else if (is_div_op(req.op)) begin
                        state_d = S_DIV_CALC;
                    end else begin
                        result_d = req.hilo;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (cnt_q == MUL_LAST) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV_CALC: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_DIV_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV_FIX: begin
                if (div_done) begin
                    result_d = {div_rem, div_quo};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                resp.valid = 1'b1;
                resp.ready = 1'b1;
                resp.hilo  = result_q;
                if (!stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush discards any in-flight work; IDLE pass-through above is left intact.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            if (state_q != S_IDLE) begin
                resp = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
